// File: rtl/mpf_prim_fifo_lutram_pkg.sv
// rtl/mpf_prim_fifo_lutram_pkg.sv - shared helpers for the LUT-RAM FIFO primitives
package mpf_prim_fifo_lutram_pkg;

    // Number of address bits needed to index 'value' entries.
    function automatic int mpf_clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mpf_prim_lutram_ram.sv
// rtl/mpf_prim_lutram_ram.sv - LUT RAM with synchronous write and combinational read
module mpf_prim_lutram_ram
    import mpf_prim_fifo_lutram_pkg::*;
#(
    parameter int N_ENTRIES   = 2,
    parameter int N_DATA_BITS = 32
) (
    input  logic                               clk,
    input  logic [mpf_clog2(N_ENTRIES)-1:0]    raddr,
    output logic [N_DATA_BITS-1:0]             rdata,
    input  logic [mpf_clog2(N_ENTRIES)-1:0]    waddr,
    input  logic                               wen,
    input  logic [N_DATA_BITS-1:0]             wdata
);

    logic [N_DATA_BITS-1:0] mem [N_ENTRIES];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mpf_prim_fifo_lutram.sv
// rtl/mpf_prim_fifo_lutram.sv - LUT-RAM FIFO with optional registered/bypassed output stage
module mpf_prim_fifo_lutram
    import mpf_prim_fifo_lutram_pkg::*;
#(
    parameter int N_DATA_BITS        = 32,
    parameter int N_ENTRIES          = 2,
    parameter int THRESHOLD          = 1,
    parameter int REGISTER_OUTPUT    = 0,
    parameter int BYPASS_TO_REGISTER = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_DATA_BITS-1:0] enq_data,
    input  logic                   enq_en,
    output logic                   notFull,
    output logic                   almostFull,
    output logic [N_DATA_BITS-1:0] first,
    input  logic                   deq_en,
    output logic                   notEmpty
);

    localparam int PTR_BITS = mpf_clog2(N_ENTRIES);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(N_ENTRIES);

    logic [PTR_BITS-1:0]    wr_ptr;
    logic [PTR_BITS-1:0]    rd_ptr;
    logic [CNT_BITS-1:0]    cnt;
    logic [CNT_BITS-1:0]    free_slots;
    logic [N_DATA_BITS-1:0] ram_rdata;
    logic                   ram_empty;
    logic                   enq_ok;
    logic                   ram_wen;
    logic                   ram_ren;
    logic                   bypass;

    // Full/almost-full track RAM occupancy only, from registered state.
    assign ram_empty  = (cnt == '0);
    assign notFull    = (cnt != CNT_FULL);
    assign free_slots = CNT_FULL - cnt;
    assign almostFull = (int'(free_slots) <= THRESHOLD);
    assign enq_ok     = enq_en && notFull;
    assign ram_wen    = enq_ok && !bypass;

    mpf_prim_lutram_ram #(
        .N_ENTRIES   (N_ENTRIES),
        .N_DATA_BITS (N_DATA_BITS)
    ) u_ram (
        .clk   (clk),
        .raddr (rd_ptr),
        .rdata (ram_rdata),
        .waddr (wr_ptr),
        .wen   (ram_wen),
        .wdata (enq_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (ram_wen) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (ram_ren) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            if (ram_wen && !ram_ren) begin
                cnt <= cnt + CNT_BITS'(1);
            end else if (!ram_wen && ram_ren) begin
                cnt <= cnt - CNT_BITS'(1);
            end
        end
    end

    if (REGISTER_OUTPUT != 0) begin : g_reg_out
        logic                   out_valid;
        logic [N_DATA_BITS-1:0] out_data;
        logic                   load;

        // The register refills whenever it is empty or being consumed.
        assign load    = !out_valid || deq_en;
        assign ram_ren = load && !ram_empty;
        assign bypass  = (BYPASS_TO_REGISTER != 0) && load && ram_empty && enq_ok;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end else if (load) begin
                if (!ram_empty) begin
                    out_data  <= ram_rdata;
                    out_valid <= 1'b1;
                end else if (bypass) begin
                    out_data  <= enq_data;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end

        assign first    = out_data;
        assign notEmpty = out_valid;
    end else begin : g_comb_out
        // An enqueue into an empty RAM is not visible yet, so a same-cycle dequeue is dropped.
        assign ram_ren  = deq_en && !ram_empty;
        assign bypass   = 1'b0;
        assign first    = ram_rdata;
        assign notEmpty = !ram_empty;
    end

    a_enq_when_full : assert property (@(posedge clk) disable iff (!reset) enq_en |-> notFull)
        else $warning("mpf_prim_fifo_lutram: enqueue while full ignored");
    a_deq_when_empty : assert property (@(posedge clk) disable iff (!reset) deq_en |-> notEmpty)
        else $warning("mpf_prim_fifo_lutram: dequeue while empty ignored");

endmodule

// File: tb/tb_mpf_prim_fifo_lutram.sv
// tb/tb_mpf_prim_fifo_lutram.sv - self-checking bench for mpf_prim_fifo_lutram in all output modes
module tb_mpf_prim_fifo_lutram;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int THR   = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Index 0: combinational output, 1: registered + bypass, 2: registered, no bypass.
    logic [DW-1:0] enq_data [3];
    logic          enq_en   [3];
    logic          deq_en   [3];
    logic          not_full [3];
    logic          almost_full [3];
    logic          not_empty [3];
    logic [DW-1:0] first_q  [3];

    int checks = 0;
    int errors = 0;

    mpf_prim_fifo_lutram #(.N_DATA_BITS(DW), .N_ENTRIES(DEPTH), .THRESHOLD(THR),
        .REGISTER_OUTPUT(0), .BYPASS_TO_REGISTER(0)) u_comb (
        .clk(clk), .reset(reset), .enq_data(enq_data[0]), .enq_en(enq_en[0]),
        .notFull(not_full[0]), .almostFull(almost_full[0]), .first(first_q[0]),
        .deq_en(deq_en[0]), .notEmpty(not_empty[0]));

    mpf_prim_fifo_lutram #(.N_DATA_BITS(DW), .N_ENTRIES(DEPTH), .THRESHOLD(THR),
        .REGISTER_OUTPUT(1), .BYPASS_TO_REGISTER(1)) u_byp (
        .clk(clk), .reset(reset), .enq_data(enq_data[1]), .enq_en(enq_en[1]),
        .notFull(not_full[1]), .almostFull(almost_full[1]), .first(first_q[1]),
        .deq_en(deq_en[1]), .notEmpty(not_empty[1]));

    mpf_prim_fifo_lutram #(.N_DATA_BITS(DW), .N_ENTRIES(DEPTH), .THRESHOLD(THR),
        .REGISTER_OUTPUT(1), .BYPASS_TO_REGISTER(0)) u_nobyp (
        .clk(clk), .reset(reset), .enq_data(enq_data[2]), .enq_en(enq_en[2]),
        .notFull(not_full[2]), .almostFull(almost_full[2]), .first(first_q[2]),
        .deq_en(deq_en[2]), .notEmpty(not_empty[2]));

    // Reference model: ordered RAM contents plus an optional output slot.
    logic [DW-1:0] mram [3][DEPTH];
    int            mcnt [3];
    bit            mov  [3];
    logic [DW-1:0] mod  [3];

    function automatic bit is_reg(int d);
        return d != 0;
    endfunction

    function automatic bit is_byp(int d);
        return d == 1;
    endfunction

    function automatic bit exp_ne(int d);
        return is_reg(d) ? mov[d] : (mcnt[d] != 0);
    endfunction

    function automatic logic [DW-1:0] exp_first(int d);
        return is_reg(d) ? mod[d] : mram[d][0];
    endfunction

    function automatic bit exp_nf(int d);
        return mcnt[d] != DEPTH;
    endfunction

    function automatic bit exp_af(int d);
        return (DEPTH - mcnt[d]) <= THR;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            mcnt[d] = 0;
            mov[d]  = 1'b0;
            mod[d]  = '0;
        end
    endtask

    task automatic model_push(int d, logic [DW-1:0] v);
        mram[d][mcnt[d]] = v;
        mcnt[d] = mcnt[d] + 1;
    endtask

    task automatic model_pop(int d, output logic [DW-1:0] v);
        v = mram[d][0];
        for (int i = 0; i < DEPTH - 1; i++) mram[d][i] = mram[d][i + 1];
        mcnt[d] = mcnt[d] - 1;
    endtask

    task automatic model_step(int d);
        bit take_enq;
        logic [DW-1:0] v;
        take_enq = enq_en[d] && (mcnt[d] < DEPTH);
        if (!is_reg(d)) begin
            if (deq_en[d] && mcnt[d] > 0) model_pop(d, v);
        end else if (!mov[d] || deq_en[d]) begin
            if (mcnt[d] > 0) begin
                model_pop(d, v);
                mod[d] = v;
                mov[d] = 1'b1;
            end else if (take_enq && is_byp(d)) begin
                mod[d]   = enq_data[d];
                mov[d]   = 1'b1;
                take_enq = 1'b0;
            end else begin
                mov[d] = 1'b0;
            end
        end
        if (take_enq) model_push(d, enq_data[d]);
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 3; d++) begin
            enq_en[d]   = 1'b0;
            deq_en[d]   = 1'b0;
            enq_data[d] = '0;
        end
    endtask

    task automatic tick();
        if (!reset) model_clear();
        else for (int d = 0; d < 3; d++) model_step(d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (not_empty[d] !== 1'b0) begin
                errors++; $display("FAIL reset_not_empty dut%0d got %b want 0", d, not_empty[d]);
            end
            checks++;
            if (not_full[d] !== 1'b1) begin
                errors++; $display("FAIL reset_not_full dut%0d got %b want 1", d, not_full[d]);
            end
            checks++;
            if (almost_full[d] !== 1'b0) begin
                errors++; $display("FAIL reset_almost_full dut%0d got %b want 0", d, almost_full[d]);
            end
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            enq_en[0] = 1'b1; enq_data[0] = 32'hA1 + i;
            tick();
        end
        enq_en[0] = 1'b0;
        checks++;
        if (almost_full[0] !== 1'b1 || not_full[0] !== 1'b1) begin
            errors++; $display("FAIL fill3_flags got af=%b nf=%b want af=1 nf=1", almost_full[0], not_full[0]);
        end
        enq_en[0] = 1'b1; enq_data[0] = 32'hA4;
        tick();
        checks++;
        if (not_full[0] !== 1'b0) begin
            errors++; $display("FAIL fill4_not_full got %b want 0", not_full[0]);
        end
        enq_data[0] = 32'hA5;
        tick();
        enq_en[0] = 1'b0;
        checks++;
        if (not_full[0] !== 1'b0 || first_q[0] !== 32'hA1) begin
            errors++; $display("FAIL overflow_ignored got nf=%b first=%h want nf=0 first=a1", not_full[0], first_q[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (not_empty[0] !== 1'b1 || first_q[0] !== 32'hA1 + i) begin
                errors++; $display("FAIL drain_%0d got ne=%b first=%h want ne=1 first=%h", i, not_empty[0], first_q[0], 32'hA1 + i);
            end
            deq_en[0] = 1'b1;
            tick();
            deq_en[0] = 1'b0;
        end
        checks++;
        if (not_empty[0] !== 1'b0 || not_full[0] !== 1'b1 || almost_full[0] !== 1'b0) begin
            errors++; $display("FAIL drained_flags got ne=%b nf=%b af=%b want 0 1 0", not_empty[0], not_full[0], almost_full[0]);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        enq_en[1] = 1'b1; enq_data[1] = 32'h55;
        checks++;
        if (not_empty[1] !== 1'b0) begin
            errors++; $display("FAIL bypass_pre_empty got %b want 0", not_empty[1]);
        end
        tick();
        enq_en[1] = 1'b0;
        checks++;
        if (not_empty[1] !== 1'b1 || first_q[1] !== 32'h55) begin
            errors++; $display("FAIL bypass_latency got ne=%b first=%h want ne=1 first=55", not_empty[1], first_q[1]);
        end
        checks++;
        if (not_full[1] !== 1'b1 || almost_full[1] !== 1'b0) begin
            errors++; $display("FAIL bypass_flags got nf=%b af=%b want 1 0", not_full[1], almost_full[1]);
        end
        deq_en[1] = 1'b1;
        tick();
        deq_en[1] = 1'b0;
        checks++;
        if (not_empty[1] !== 1'b0) begin
            errors++; $display("FAIL bypass_drain got %b want 0", not_empty[1]);
        end
    endtask

    task automatic test_no_bypass();
        idle_inputs();
        enq_en[2] = 1'b1; enq_data[2] = 32'h55;
        tick();
        enq_en[2] = 1'b0;
        checks++;
        if (not_empty[2] !== 1'b0) begin
            errors++; $display("FAIL nobyp_cycle1 got %b want 0", not_empty[2]);
        end
        tick();
        checks++;
        if (not_empty[2] !== 1'b1 || first_q[2] !== 32'h55) begin
            errors++; $display("FAIL nobyp_cycle2 got ne=%b first=%h want ne=1 first=55", not_empty[2], first_q[2]);
        end
        deq_en[2] = 1'b1;
        tick();
        deq_en[2] = 1'b0;
        checks++;
        if (not_empty[2] !== 1'b0) begin
            errors++; $display("FAIL nobyp_drain got %b want 0", not_empty[2]);
        end
    endtask

    task automatic test_streaming();
        int next_exp [3];
        idle_inputs();
        for (int d = 0; d < 3; d++) next_exp[d] = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            for (int d = 0; d < 3; d++) begin
                enq_en[d]   = (cyc < 20);
                enq_data[d] = cyc;
                deq_en[d]   = not_empty[d];
                if (not_empty[d]) begin
                    checks++;
                    if (first_q[d] !== DW'(next_exp[d])) begin
                        errors++; $display("FAIL stream_order dut%0d got %0d want %0d", d, first_q[d], next_exp[d]);
                    end
                    next_exp[d]++;
                end
            end
            tick();
        end
        idle_inputs();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (next_exp[d] != 20 || not_empty[d] !== 1'b0) begin
                errors++; $display("FAIL stream_count dut%0d got %0d ne=%b want 20 ne=0", d, next_exp[d], not_empty[d]);
            end
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (not_empty[d] !== exp_ne(d)) begin
                    errors++; $display("FAIL rand_ne dut%0d cyc%0d got %b want %b", d, c, not_empty[d], exp_ne(d));
                end
                checks++;
                if (not_full[d] !== exp_nf(d)) begin
                    errors++; $display("FAIL rand_nf dut%0d cyc%0d got %b want %b", d, c, not_full[d], exp_nf(d));
                end
                checks++;
                if (almost_full[d] !== exp_af(d)) begin
                    errors++; $display("FAIL rand_af dut%0d cyc%0d got %b want %b", d, c, almost_full[d], exp_af(d));
                end
                if (exp_ne(d)) begin
                    checks++;
                    if (first_q[d] !== exp_first(d)) begin
                        errors++; $display("FAIL rand_first dut%0d cyc%0d got %h want %h", d, c, first_q[d], exp_first(d));
                    end
                end
                enq_en[d]   = (($urandom_range(0, 3) != 0) && not_full[d]) || ($urandom_range(0, 31) == 0);
                deq_en[d]   = (($urandom_range(0, 2) != 0) && not_empty[d]) || ($urandom_range(0, 31) == 0);
                enq_data[d] = $urandom;
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        for (int d = 0; d < 3; d++) deq_en[d] = not_empty[d];
        for (int k = 0; k < 8; k++) tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            for (int d = 0; d < 3; d++) begin
                enq_en[d] = 1'b1; enq_data[d] = 32'hD1 + i;
            end
            tick();
        end
        idle_inputs();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (not_empty[d] !== 1'b1) begin
                errors++; $display("FAIL pre_reset_ne dut%0d got %b want 1", d, not_empty[d]);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (not_empty[d] !== 1'b0 || not_full[d] !== 1'b1 || almost_full[d] !== 1'b0) begin
                errors++; $display("FAIL async_reset dut%0d got ne=%b nf=%b af=%b want 0 1 0", d, not_empty[d], not_full[d], almost_full[d]);
            end
        end
        model_clear();
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (not_empty[d] !== 1'b0 || not_full[d] !== 1'b1) begin
                    errors++; $display("FAIL post_reset_idle dut%0d got ne=%b nf=%b want 0 1", d, not_empty[d], not_full[d]);
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            enq_en[d] = 1'b1; enq_data[d] = 32'hE0;
        end
        tick();
        idle_inputs();
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (not_empty[d] !== 1'b1 || first_q[d] !== 32'hE0) begin
                errors++; $display("FAIL post_reset_data dut%0d got ne=%b first=%h want 1 e0", d, not_empty[d], first_q[d]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_clear();
        test_reset();
        test_fill_drain();
        test_bypass();
        test_no_bypass();
        test_streaming();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
